// File: rtl/pipe_stage_skid.sv
// Pipeline stage register carrying a PC and payload word over a valid/ready
// handshake. With SKID_EN=1 a second (skid) entry lets in_ready come purely
// from a flop. Synchronous flush zeroes the data and drops the current input
// beat. Saturating stall and flush-drop counters are exported for the hazard
// and performance logic.
//
// state | meaning
// ------+---------------------------------------------------------------
// EMPTY | no entry held, out_valid=0
// ONE   | main entry valid and driving out_*
// TWO   | main and skid entries valid, in_ready=0 (SKID_EN=1 only)
module pipe_stage_skid #(
    parameter int PC_W    = 32,
    parameter int DATA_W  = 32,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_ready_q;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              in_xfer, out_xfer;
    logic [1:0]        drop_add;
    logic [CNT_W:0]    drop_sum;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_pc    = main_pc_q;
    assign out_data  = main_data_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;
    assign drop_cnt  = drop_q;

    // In skid mode in_ready is a flop; single-entry mode looks through to out_ready.
    assign in_ready = (SKID_EN != 0) ? in_ready_q : (!out_valid || out_ready);

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Entries held at a flush edge that are not leaving downstream this cycle.
    assign drop_add = state_q - {1'b0, out_xfer};
    assign drop_sum = {1'b0, drop_q} + {{(CNT_W-1){1'b0}}, drop_add};

    // Next-state, entry data and counter updates.
    always_comb begin
        state_d     = state_q;
        main_pc_d   = main_pc_q;
        main_data_d = main_data_q;
        skid_pc_d   = skid_pc_q;
        skid_data_d = skid_data_q;
        stall_d     = stall_q;
        drop_d      = drop_q;

        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        if (flush) begin
            state_d     = ST_EMPTY;
            main_pc_d   = '0;
            main_data_d = '0;
            skid_pc_d   = '0;
            skid_data_d = '0;
            drop_d      = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d     = ST_ONE;
                        main_pc_d   = in_pc;
                        main_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_pc_d   = in_pc;
                        main_data_d = in_data;
                    end else if (in_xfer) begin
                        // Only reachable in skid mode; single-entry in_ready is low here.
                        state_d     = ST_TWO;
                        skid_pc_d   = in_pc;
                        skid_data_d = in_data;
                    end else if (out_xfer) begin
                        // Data flops keep their last value after draining.
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        state_d     = ST_ONE;
                        main_pc_d   = skid_pc_q;
                        main_data_d = skid_data_q;
                        skid_pc_d   = '0;
                        skid_data_d = '0;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_EMPTY;
            main_pc_q   <= '0;
            main_data_q <= '0;
            skid_pc_q   <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
            stall_q     <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            main_pc_q   <= main_pc_d;
            main_data_q <= main_data_d;
            skid_pc_q   <= skid_pc_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= (state_d != ST_TWO);
            stall_q     <= stall_d;
            drop_q      <= drop_d;
        end
    end

    // Protocol checks: occupancy bound, full implies not ready, stalled output holds.
    always @(posedge clk) begin
        if (rstn) begin
            assert (state_q <= ((SKID_EN != 0) ? ST_TWO : ST_ONE));
            assert (!(state_q == ST_TWO && in_ready));
            if (!flush && out_valid && !out_ready) begin
                assert (main_pc_d == main_pc_q && main_data_d == main_data_q);
            end
        end
    end

endmodule
